nibble_add_seq: RTL and testbench

- Controller that sequences the team's existing 4-bit adder (sw/btn operand entry, sum/carry result) to perform one wide addition.
- Collects two multi-nibble operands from the 4-bit switch bus under button control.
- Feeds the operands through the external 4-bit adder one nibble per cycle, LSB first, and chains the carry between nibbles.
- Sits between the board switch/button inputs and the 4-bit adder instance.

---
 rtl/nibble_add_seq_if.sv | 25 ++
 rtl/nibble_add_seq.sv | 132 +++++++++++++
 tb/tb_nibble_add_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Nibble-wide adder bus between the wide-add sequencer (master) and the
// external combinational 4-bit adder (slave).
interface nibble_add_seq_if;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;

  modport master (
    output add_a,
    output add_b,
    output add_cin,
    input  add_sum,
    input  add_cout
  );

  modport slave (
    input  add_a,
    input  add_b,
    input  add_cin,
    output add_sum,
    output add_cout
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Wide adder built by stepping an external 4-bit adder LSB nibble first.
// Optional NIBBLE_ADD_SUB_EN adds a sub input selecting A - B.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           sw,
  input  logic [1:0]           btn,
  input  logic                 start,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic                 sub,
`endif
  nibble_add_seq_if.master     adder,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry,
  output logic                 busy,
  output logic                 done
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic [IDXW-1:0] r_idx;
  logic [1:0]      r_btn_q;
  logic            r_sub;
  logic            r_carry;
  logic            r_busy;
  logic            r_done;
  logic [3:0]      r_add_a;
  logic [3:0]      r_add_b;
  logic            r_add_cin;

  logic [1:0]      w_rise;
  logic            w_sub_in;
  logic [IDXW-1:0] w_idx_nxt;
  logic [3:0]      w_a_nib [NIBBLES];
  logic [3:0]      w_b_nib [NIBBLES];

  assign w_rise    = btn & ~r_btn_q;
  assign w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

`ifdef NIBBLE_ADD_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign w_a_nib[gi] = r_a[4*gi +: 4];
      assign w_b_nib[gi] = r_b[4*gi +: 4];
    end
  endgenerate

  // Adder operands are registered one nibble ahead: each capture edge also
  // presents the next nibble and forwards add_cout as the next carry-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_idx     <= '0;
      r_btn_q   <= '0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
    end else begin
      r_btn_q <= btn;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise != 2'b00) begin
            if (w_rise[0]) r_a <= {r_a[W-5:0], sw};
            if (w_rise[1]) r_b <= {r_b[W-5:0], sw};
          end else if (start) begin
            r_state   <= S_ADD;
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_sub     <= w_sub_in;
            r_add_a   <= w_a_nib[0];
            r_add_b   <= w_b_nib[0] ^ {4{w_sub_in}};
            r_add_cin <= w_sub_in;
          end
        end
        S_ADD: begin
          r_result[{r_idx, 2'b00} +: 4] <= adder.add_sum;
          r_idx <= w_idx_nxt;
          if (r_idx == LAST_IDX) begin
            r_state   <= S_DONE;
            r_carry   <= adder.add_cout;
            r_done    <= 1'b1;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
          end else begin
            r_add_a   <= w_a_nib[w_idx_nxt];
            r_add_b   <= w_b_nib[w_idx_nxt] ^ {4{r_sub}};
            r_add_cin <= adder.add_cout;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign adder.add_a   = r_add_a;
  assign adder.add_b   = r_add_b;
  assign adder.add_cin = r_add_cin;
  assign result        = r_result;
  assign carry         = r_carry;
  assign busy          = r_busy;
  assign done          = r_done;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: arithmetic reference model checked every cycle,
// directed scenarios with literal results, then randomized stimulus.
module tb_nibble_add_seq;
  localparam int N = 4;
  localparam int W = 4 * N;
  localparam logic [63:0] MASK = (64'd1 << W) - 1;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic [3:0]   sw    = '0;
  logic [1:0]   btn   = '0;
  logic         start = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic [W-1:0] result;
  logic         carry;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference state: phase 0 idle, 1..N presenting nibble phase-1, N+1 done.
  int          m_phase = 0;
  logic [63:0] m_a = '0, m_b = '0, m_opa = '0, m_opb = '0, m_res = '0;
  logic        m_car = 1'b0, m_s = 1'b0;
  logic [1:0]  m_btnq = '0;
  logic        cin_log [0:15];

  nibble_add_seq_if ifc ();
  assign {ifc.add_cout, ifc.add_sum} = {1'b0, ifc.add_a} + {1'b0, ifc.add_b} + {4'b0, ifc.add_cin};

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .btn    (btn),
    .start  (start),
`ifdef NIBBLE_ADD_SUB_EN
    .sub    (sub),
`endif
    .adder  (ifc),
    .result (result),
    .carry  (carry),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [1:0]  rise;
    logic [63:0] sum;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_a = '0; m_b = '0; m_res = '0; m_car = 1'b0; m_btnq = '0;
      end else begin
        rise   = btn & ~m_btnq;
        m_btnq = btn;
        if (m_phase == 0) begin
          if (rise != 2'b00) begin
            if (rise[0]) m_a = ((m_a << 4) | 64'(sw)) & MASK;
            if (rise[1]) m_b = ((m_b << 4) | 64'(sw)) & MASK;
          end else if (start) begin
            m_phase = 1;
`ifdef NIBBLE_ADD_SUB_EN
            m_s = sub;
`else
            m_s = 1'b0;
`endif
            m_opa = m_a;
            m_opb = m_s ? (~m_b & MASK) : m_b;
          end
        end else if (m_phase <= N) begin
          m_phase++;
          if (m_phase == N + 1) begin
            sum   = m_opa + m_opb + 64'(m_s);
            m_res = sum & MASK;
            m_car = sum[W];
          end
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  task automatic compare();
    logic [63:0] ea, eb, ec, lm;
    int k;
    ea = '0; eb = '0; ec = '0;
    if (m_phase >= 1 && m_phase <= N) begin
      k  = m_phase - 1;
      lm = (64'd1 << (4 * k)) - 1;
      ea = (m_opa >> (4 * k)) & 64'hF;
      eb = (m_opb >> (4 * k)) & 64'hF;
      ec = (((m_opa & lm) + (m_opb & lm) + 64'(m_s)) >> (4 * k)) & 64'h1;
    end
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("done", 64'(done), 64'(m_phase == N + 1));
    check("add_a", 64'(ifc.add_a), ea);
    check("add_b", 64'(ifc.add_b), eb);
    check("add_cin", 64'(ifc.add_cin), ec);
    if (m_phase == 0 || m_phase == N + 1) begin
      check("result", 64'(result), m_res);
      check("carry", 64'(carry), 64'(m_car));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) compare();
    end
  end

  task automatic press(input logic [1:0] which, input logic [3:0] val);
    @(negedge clk);
    sw  = val;
    btn = which;
    @(negedge clk);
    btn = 2'b00;
  endtask

  task automatic load(input logic [1:0] which, input logic [W-1:0] val);
    for (int i = N - 1; i >= 0; i--) press(which, val[4*i +: 4]);
  endtask

  // Starts an operation and waits a bounded number of cycles for done;
  // with noisy set, start and btn[0] (sw=F) are toggled during ADD.
  task automatic run_op(input string name, input logic [W-1:0] exp_res, input logic exp_car,
                        input bit noisy);
    int lat;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= N + 4; i++) begin
      @(negedge clk);
      if (i < 16) cin_log[i] = ifc.add_cin;
      if (done && lat < 0) lat = i - 1;
      if (noisy && i <= 4) begin
        start = (i == 1 || i == 3);
        btn   = {1'b0, i[0]};
        sw    = 4'hF;
      end else begin
        start = 1'b0;
        btn   = 2'b00;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(N));
    check({name, " result"}, 64'(result), 64'(exp_res));
    check({name, " carry"}, 64'(carry), 64'(exp_car));
    $display("[TB] op %s: result=0x%0h carry=%0d done_after=%0d", name, result, carry, lat);
  endtask

  initial begin
    int dones;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset carry", 64'(carry), 64'd0);
    check("reset add_a", 64'(ifc.add_a), 64'd0);

    load(2'b01, 16'h1234);
    load(2'b10, 16'h0FFF);
    run_op("1234+0FFF", 16'h2233, 1'b0, 1'b0);

    load(2'b01, 16'hFFFF);
    load(2'b10, 16'h0001);
    run_op("FFFF+0001", 16'h0000, 1'b1, 1'b0);
    check("cin nib0", 64'(cin_log[1]), 64'd0);
    check("cin nib1", 64'(cin_log[2]), 64'd1);
    check("cin nib2", 64'(cin_log[3]), 64'd1);
    check("cin nib3", 64'(cin_log[4]), 64'd1);

    // Reset during the second ADD cycle aborts the operation.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort result", 64'(result), 64'd0);
    check("abort add_a", 64'(ifc.add_a), 64'd0);
    check("abort add_b", 64'(ifc.add_b), 64'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    $display("[TB] op abort: busy=%0d result=0x%0h", busy, result);

    load(2'b01, 16'h1111);
    load(2'b10, 16'h2222);
    run_op("noisy 1111+2222", 16'h3333, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("noise no restart", 64'(busy), 64'd0);
    run_op("repeat 1111+2222", 16'h3333, 1'b0, 1'b0);

    // Dual edge plus start in IDLE: both operands load 0xA, start is ignored.
    @(negedge clk);
    sw = 4'hA; btn = 2'b11; start = 1'b1;
    @(negedge clk);
    btn = 2'b00; start = 1'b0;
    check("load beats start", 64'(busy), 64'd0);
    @(negedge clk);
    check("load beats start 2", 64'(busy), 64'd0);
    run_op("111A+222A", 16'h3344, 1'b0, 1'b0);

`ifdef NIBBLE_ADD_SUB_EN
    load(2'b01, 16'h0005);
    load(2'b10, 16'h0007);
    sub = 1'b1;
    run_op("0005-0007", 16'hFFFE, 1'b0, 1'b0);
    load(2'b01, 16'h0007);
    load(2'b10, 16'h0005);
    run_op("0007-0005", 16'h0002, 1'b1, 1'b0);
    sub = 1'b0;
`endif

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      sw = 4'($urandom);
      if ($urandom_range(0, 2) == 0) btn = 2'($urandom);
      if (((cyc / 400) % 3) == 2) start = 1'b1;
      else start = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 149) == 0);
`ifdef NIBBLE_ADD_SUB_EN
      sub = 1'($urandom);
`endif
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; btn = 2'b00;
    repeat (N + 3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
